// File: rtl/sap_pkg.sv
// Shared SAP CPU definitions: program-loader FSM states and loader error codes.
package sap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    RELEASE,
    ERROR
  } loader_state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_CSUM   = 2'b01;
  localparam logic [1:0] ERR_OVF    = 2'b10;
  localparam logic [1:0] ERR_VERIFY = 2'b11;

endpackage

// File: rtl/prog_loader.sv
// Program loader for the SAP CPU: streams an image into program memory, checks its
// trailing checksum, reads it back to verify, then releases the CPU from reset.
module prog_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   byte_count
);

  localparam int              CNT_W    = ADDR_W + 1;
  localparam int              HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(2 ** ADDR_W);

  loader_state_t state_q, state_d;

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] vsum_q;
  logic [CNT_W-1:0]  vcnt_q;
  logic              rd_pending_q;
  logic [HOLD_W-1:0] hold_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic              data_beat, last_beat, full, verify_end;
  logic              start_load, set_err;
  logic [1:0]        err_val;
  logic [DATA_W-1:0] csum, vsum_final;

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign data_beat  = in_valid && in_ready && !in_last;
  assign last_beat  = in_valid && in_ready && in_last;
  assign full       = (byte_count == CAPACITY);
  assign csum       = sum_q + in_data;

  // Reads are issued combinationally so VERIFY takes exactly byte_count+1 cycles:
  // one per address, plus one for the final read data to return.
  assign mem_re     = (state_q == VERIFY) && (vcnt_q < byte_count);
  assign mem_addr   = mem_re ? vcnt_q[ADDR_W-1:0] : wr_addr_q;
  assign vsum_final = rd_pending_q ? vsum_q + mem_rdata : vsum_q;
  assign verify_end = (state_q == VERIFY) && (vcnt_q == byte_count);

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    start_load = 1'b0;
    set_err    = 1'b0;
    err_val    = ERR_NONE;
    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          state_d    = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        if (last_beat) begin
          if (csum == '0) begin
            state_d = VERIFY;
          end else begin
            state_d = ERROR;
            set_err = 1'b1;
            err_val = ERR_CSUM;
          end
        end else if (data_beat && full) begin
          state_d = ERROR;
          set_err = 1'b1;
          err_val = ERR_OVF;
        end
      end
      VERIFY: begin
        if (verify_end) begin
          if (vsum_final == sum_q) begin
            state_d = RELEASE;
          end else begin
            state_d = ERROR;
            set_err = 1'b1;
            err_val = ERR_VERIFY;
          end
        end
      end
      RELEASE: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears only the loader's own registers; the program memory keeps whatever
  // was written before an abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      wr_addr_q    <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      byte_count   <= '0;
      sum_q        <= '0;
      vsum_q       <= '0;
      vcnt_q       <= '0;
      rd_pending_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here sees pre-edge values.
      state_q <= state_d;
      mem_we  <= 1'b0;
      hold_q  <= (state_q == RELEASE) ? hold_q + HOLD_W'(1) : '0;

      if (start_load) begin
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        err        <= 1'b0;
        err_code   <= ERR_NONE;
        byte_count <= '0;
        sum_q      <= '0;
      end

      if (data_beat && !full) begin
        mem_we     <= 1'b1;
        wr_addr_q  <= byte_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        byte_count <= byte_count + CNT_W'(1);
        sum_q      <= csum;
      end

      if (last_beat) begin
        vcnt_q       <= '0;
        vsum_q       <= '0;
        rd_pending_q <= 1'b0;
      end

      if (state_q == VERIFY) begin
        vcnt_q       <= vcnt_q + CNT_W'(1);
        rd_pending_q <= mem_re;
        vsum_q       <= vsum_final;
      end

      if (state_q == RELEASE && state_d == IDLE) begin
        cpu_hold <= 1'b0;
        done     <= 1'b1;
      end

      if (set_err) begin
        err      <= 1'b1;
        err_code <= err_val;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with a behavioural program memory.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [4:0] byte_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [16];
  logic       corrupt = 1'b0;

  int         wr_cnt = 0;
  int         re_cnt = 0;
  int         overlap = 0;
  logic [3:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [3:0] re_addr_log [64];

  logic [7:0] prog [5] = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0};

  prog_loader #(.ADDR_W(4), .DATA_W(8), .HOLD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Program memory: synchronous write, one-cycle read latency, optional readback fault at 2.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (corrupt && mem_addr == 4'd2) ? mem[mem_addr] + 8'h01 : mem[mem_addr];
  end

  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = mem_addr;
        wr_data_log[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
    if (mem_re) begin
      if (re_cnt < 64) re_addr_log[re_cnt] = mem_addr;
      re_cnt++;
    end
    if (mem_we && mem_re) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int gap);
    int w;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_bound", 32'(w < 50), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_prog(input logic [7:0] last_b, input bit gaps);
    for (int i = 0; i < 5; i++) send(prog[i], 1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
    send(last_b, 1'b1, gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_settle(output int n);
    n = 0;
    while (busy && !err && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("settle_bound", 32'(n < 200), 1);
  endtask

  task automatic check_prog_writes(input string tag, input int base);
    check({tag, "_wr_count"}, wr_cnt - base, 5);
    for (int i = 0; i < 5; i++) begin
      check({tag, "_wr_addr"}, wr_addr_log[base + i], i);
      check({tag, "_wr_data"}, wr_data_log[base + i], prog[i]);
    end
  endtask

  initial begin
    int n;
    int wb;
    int rb;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    rst = 1'b1;
    @(negedge clk);

    // Normal load
    wb = wr_cnt; rb = re_cnt;
    pulse_start();
    check("load_in_ready", in_ready, 1);
    check("load_cpu_hold", cpu_hold, 1);
    check("load_busy", busy, 1);
    send_prog(8'hE2, 1'b0);
    wait_settle(n);
    check("norm_latency", n, 8);
    check_prog_writes("norm", wb);
    check("norm_byte_count", byte_count, 5);
    check("norm_re_count", re_cnt - rb, 5);
    for (int i = 0; i < 5; i++) check("norm_re_addr", re_addr_log[rb + i], i);
    check("norm_done", done, 1);
    check("norm_err", err, 0);
    check("norm_cpu_hold", cpu_hold, 0);

    // Bad checksum
    wb = wr_cnt; rb = re_cnt;
    pulse_start();
    check("csum_done_cleared", done, 0);
    send_prog(8'hE3, 1'b0);
    repeat (3) @(negedge clk);
    check("csum_err", err, 1);
    check("csum_err_code", err_code, 2'b01);
    check("csum_cpu_hold", cpu_hold, 1);
    check("csum_in_ready", in_ready, 0);
    check("csum_no_reads", re_cnt - rb, 0);
    check("csum_done", done, 0);

    // Overflow: 17 data bytes, no last
    wb = wr_cnt;
    pulse_start();
    check("ovf_err_cleared", err, 0);
    check("ovf_code_cleared", err_code, 0);
    for (int i = 0; i < 17; i++) send(8'(i * 7 + 3), 1'b0, 0);
    check("ovf_err", err, 1);
    check("ovf_err_code", err_code, 2'b10);
    check("ovf_byte_count", byte_count, 16);
    check("ovf_no_17th_we", mem_we, 0);
    repeat (2) @(negedge clk);
    check("ovf_wr_count", wr_cnt - wb, 16);
    for (int i = 0; i < 16; i++) check("ovf_wr_addr", wr_addr_log[wb + i], i);
    check("ovf_wr_data_15", wr_data_log[wb + 15], 8'h6C);

    // Verify mismatch
    wb = wr_cnt; rb = re_cnt;
    corrupt = 1'b1;
    pulse_start();
    send_prog(8'hE2, 1'b0);
    wait_settle(n);
    corrupt = 1'b0;
    check_prog_writes("vfy", wb);
    check("vfy_re_count", re_cnt - rb, 5);
    check("vfy_err", err, 1);
    check("vfy_err_code", err_code, 2'b11);
    check("vfy_done", done, 0);
    check("vfy_cpu_hold", cpu_hold, 1);

    // Backpressure, with a start pulse mid-load that must be ignored
    wb = wr_cnt;
    pulse_start();
    send(prog[0], 1'b0, 2);
    send(prog[1], 1'b0, 1);
    pulse_start();
    send(prog[2], 1'b0, 3);
    send(prog[3], 1'b0, int'($urandom_range(0, 3)));
    send(prog[4], 1'b0, int'($urandom_range(0, 3)));
    send(8'hE2, 1'b1, 2);
    wait_settle(n);
    check_prog_writes("bp", wb);
    check("bp_byte_count", byte_count, 5);
    check("bp_done", done, 1);
    check("bp_err", err, 0);

    // Reset after the 3rd byte
    pulse_start();
    for (int i = 0; i < 3; i++) send(prog[i], 1'b0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_cpu_hold", cpu_hold, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    check("mrst_err_code", err_code, 0);
    check("mrst_byte_count", byte_count, 0);
    check("mrst_mem_we", mem_we, 0);
    check("mrst_mem_re", mem_re, 0);
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Empty program; a byte offered together with start in IDLE is not taken
    rb = re_cnt;
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
    pulse_start();
    in_valid = 1'b0;
    send(8'h00, 1'b1, 0);
    wait_settle(n);
    check("empty_latency", n, 3);
    check("empty_done", done, 1);
    check("empty_byte_count", byte_count, 0);
    check("empty_err", err, 0);
    check("empty_no_reads", re_cnt - rb, 0);
    check("empty_cpu_hold", cpu_hold, 0);

    // Restart from ERROR
    pulse_start();
    send(8'h05, 1'b0, 0);
    send(8'h00, 1'b1, 0);
    check("rs_err", err, 1);
    check("rs_err_code", err_code, 2'b01);
    wb = wr_cnt;
    pulse_start();
    check("rs_err_cleared", err, 0);
    check("rs_in_ready", in_ready, 1);
    send_prog(8'hE2, 1'b0);
    wait_settle(n);
    check("rs_latency", n, 8);
    check_prog_writes("rs", wb);
    check("rs_done", done, 1);
    check("rs_err_final", err, 0);

    check("we_re_exclusive", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Program loader for the SAP CPU. It is the writer side of the program memory, which the CPU otherwise only reads.
- Accepts a byte stream over a valid/ready handshake and writes it into memory from address 0.
- Checks a trailing two's-complement checksum, then reads the image back to verify it.
- Holds the CPU in reset for the whole operation and releases it only after a successful load.

Parameters:
ADDR_W, 4, memory address width; capacity 2**ADDR_W bytes.
DATA_W, 8, memory word and stream byte width.
HOLD_CYCLES, 2, cycles cpu_hold stays high after a successful verify.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or ERROR.
in_valid  in  1  stream byte valid.
in_ready  out  1  loader accepts a byte; high only in LOAD.
in_data  in  DATA_W  stream byte.
in_last  in  1  marks the checksum byte, which is never written to memory.
mem_we  out  1  one-cycle memory write strobe.
mem_re  out  1  readback strobe.
mem_addr  out  ADDR_W  write/read address.
mem_wdata  out  DATA_W  write data.
mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_re.
cpu_hold  out  1  drives the CPU reset.
busy  out  1  high in any state other than IDLE.
done  out  1  sticky success flag.
err  out  1  sticky error flag.
err_code  out  2  00 none, 01 checksum, 10 overflow, 11 verify mismatch.
byte_count  out  ADDR_W+1  number of data bytes written.

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Memory contents are not touched.
  - Reset during LOAD or VERIFY aborts immediately; partially written memory is left as is.
- States: IDLE, LOAD, VERIFY, RELEASE, ERROR.
- IDLE:
  - start → LOAD.
  - Clears done, err, err_code, byte_count and the running sum.
  - Sets cpu_hold=1.
- LOAD:
  - in_ready=1. A beat is accepted on in_valid & in_ready.
  - Data beat (in_last=0):
    - Next cycle: mem_we=1 for exactly one cycle, mem_addr=byte_count, mem_wdata=in_data.
    - byte_count increments; sum += in_data mod 2**DATA_W.
  - Data beat accepted with byte_count == 2**ADDR_W → ERROR, err_code=10. No write occurs.
  - Last beat: if (sum + in_data) mod 2**DATA_W == 0 → VERIFY, else → ERROR with err_code=01.
  - A last beat with byte_count=0 is legal; checksum 0x00 passes.
  - start is ignored in this state.
  - in_ready drops the cycle after the last beat.
- VERIFY:
  - Asserts mem_re with mem_addr 0..byte_count-1, one per cycle; mem_we stays 0.
  - Each mem_rdata, sampled one cycle after its mem_re, is summed into vsum.
  - After the final read returns: vsum == stored sum → RELEASE, else → ERROR with err_code=11.
  - Latency is byte_count+1 cycles. With byte_count=0, go to RELEASE in 1 cycle.
- RELEASE:
  - cpu_hold stays 1 for HOLD_CYCLES cycles, then the FSM goes to IDLE.
  - On that exit cpu_hold=0 and done=1. done stays high until the next start.
- ERROR:
  - cpu_hold=1, err=1, in_ready=0.
  - Leaves only on start (restart from address 0) or on reset.
- Simultaneous start and in_valid in IDLE: start wins; the byte is not accepted in that cycle.
- mem_we and mem_re are never high together.

Decomposition:
- Shared package sap_pkg holds the loader_state_t enum (IDLE, LOAD, VERIFY, RELEASE, ERROR) and the err_code constants ERR_NONE, ERR_CSUM, ERR_OVF, ERR_VERIFY.
- No sub-module: a single FSM module with its counters and sum registers.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 09,1A,2B,E0,F0 and last=E2.
  - Response: five mem_we pulses at addresses 0..4 with matching data; byte_count=5; VERIFY reads 0..4; cpu_hold drops 2 cycles after verify; done=1, err=0.
- Bad checksum:
  - Stimulus: same stream with last=E3.
  - Response: ERROR, err_code=01, cpu_hold stays 1, no mem_re pulses.
- Overflow:
  - Stimulus: 17 data bytes without in_last.
  - Response: 16 writes at addresses 0..15; the 17th beat gives err_code=10 and no 17th mem_we.
- Verify mismatch:
  - Stimulus: memory model corrupts address 2 on readback (2B→2C).
  - Response: err_code=11, done=0.
- Backpressure and reset:
  - Stimulus: in_valid toggled randomly, in-range stream.
  - Response: writes identical to the normal-load case.
  - Stimulus: rst low after the 3rd byte.
  - Response: next cycle all outputs are 0 and the state is IDLE.
- Empty program and restart:
  - Stimulus: start, then last=00.
  - Response: done=1, byte_count=0.
  - Stimulus: from ERROR, start followed by a valid stream.
  - Response: load succeeds; err is cleared at start.
